// File: rtl/ysyx_22050078_pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard controller.
// The datapath side uses the master modport; the controller uses slave.
interface ysyx_22050078_pipe_hazard_ctrl_if;
    logic [4:0]  i_idu_rs1;
    logic [4:0]  i_idu_rs2;
    logic        i_idu_rs1_ren;
    logic        i_idu_rs2_ren;
    logic        i_idex_memrd;
    logic [4:0]  i_idex_rd;
    logic        i_ex_redirect;
    logic        i_ifu_valid;
    logic        i_lsu_req;
    logic        i_lsu_ack;

    logic        o_pc_wen;
    logic        o_ifid_wen;
    logic        o_ifid_bubble;
    logic        o_idex_wen;
    logic        o_idex_bubble;
    logic        o_exmem_wen;
    logic        o_exmem_bubble;
    logic        o_memwb_wen;
    logic        o_memwb_bubble;
    logic [1:0]  o_state;
    logic [31:0] o_stall_cnt;
    logic [31:0] o_flush_cnt;
    logic        o_mem_timeout;

    modport master (
        output i_idu_rs1, i_idu_rs2, i_idu_rs1_ren, i_idu_rs2_ren,
               i_idex_memrd, i_idex_rd, i_ex_redirect, i_ifu_valid,
               i_lsu_req, i_lsu_ack,
        input  o_pc_wen, o_ifid_wen, o_ifid_bubble, o_idex_wen, o_idex_bubble,
               o_exmem_wen, o_exmem_bubble, o_memwb_wen, o_memwb_bubble,
               o_state, o_stall_cnt, o_flush_cnt, o_mem_timeout
    );

    modport slave (
        input  i_idu_rs1, i_idu_rs2, i_idu_rs1_ren, i_idu_rs2_ren,
               i_idex_memrd, i_idex_rd, i_ex_redirect, i_ifu_valid,
               i_lsu_req, i_lsu_ack,
        output o_pc_wen, o_ifid_wen, o_ifid_bubble, o_idex_wen, o_idex_bubble,
               o_exmem_wen, o_exmem_bubble, o_memwb_wen, o_memwb_bubble,
               o_state, o_stall_cnt, o_flush_cnt, o_mem_timeout
    );
endinterface

// File: rtl/ysyx_22050078_pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory stalls, branch flushes,
// load-use interlocks and fetch bubbles, with stall/flush statistics.
module ysyx_22050078_pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    ysyx_22050078_pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

    state_t      state;
    state_t      state_next;
    logic        pend_flush;
    logic        pend_flush_next;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_inc;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        mem_timeout;

    logic        ms;
    logic        lu;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        redirect_acc;

    logic        pc_wen;
    logic        ifid_wen;
    logic        ifid_bubble;
    logic        idex_wen;
    logic        idex_bubble;
    logic        exmem_wen;
    logic        exmem_bubble;
    logic        memwb_wen;
    logic        memwb_bubble;

    assign ms           = bus.i_lsu_req & ~bus.i_lsu_ack;
    assign rs1_hit      = bus.i_idu_rs1_ren & (bus.i_idu_rs1 == bus.i_idex_rd);
    assign rs2_hit      = bus.i_idu_rs2_ren & (bus.i_idu_rs2 == bus.i_idex_rd);
    assign lu           = bus.i_idex_memrd & (bus.i_idex_rd != 5'd0) & (rs1_hit | rs2_hit);
    // A redirect seen during a memory stall is dropped; the held EX stage re-presents it.
    assign redirect_acc = bus.i_ex_redirect & ~ms;
    assign wait_inc     = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

    always_comb begin
        pc_wen       = 1'b1;
        ifid_wen     = 1'b1;
        ifid_bubble  = 1'b0;
        idex_wen     = 1'b1;
        idex_bubble  = 1'b0;
        exmem_wen    = 1'b1;
        exmem_bubble = 1'b0;
        memwb_wen    = 1'b1;
        memwb_bubble = 1'b0;
        if (rst) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            idex_wen  = 1'b0;
            exmem_wen = 1'b0;
            memwb_wen = 1'b0;
        end else if (ms) begin
            pc_wen       = 1'b0;
            ifid_wen     = 1'b0;
            idex_wen     = 1'b0;
            exmem_wen    = 1'b0;
            memwb_bubble = 1'b1;
        end else if (bus.i_ex_redirect) begin
            ifid_bubble = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_bubble = 1'b1;
        end else if (!bus.i_ifu_valid) begin
            pc_wen      = 1'b0;
            ifid_bubble = 1'b1;
        end
        // The instruction fetched right after a redirect is on the wrong path.
        if (!rst && !ms && state == ST_FLUSH) begin
            ifid_bubble = 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        pend_flush_next = pend_flush;
        case (state)
            ST_RUN: begin
                if (ms)
                    state_next = ST_WAIT;
                else if (bus.i_ex_redirect)
                    state_next = ST_FLUSH;
                else
                    state_next = ST_RUN;
            end
            ST_FLUSH: begin
                if (ms) begin
                    state_next      = ST_WAIT;
                    pend_flush_next = 1'b1;
                end else if (bus.i_ex_redirect) begin
                    state_next = ST_FLUSH;
                end else begin
                    state_next = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (ms) begin
                    state_next = ST_WAIT;
                end else begin
                    state_next      = (pend_flush || bus.i_ex_redirect) ? ST_FLUSH : ST_RUN;
                    pend_flush_next = 1'b0;
                end
            end
            default: begin
                state_next      = ST_RUN;
                pend_flush_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            pend_flush  <= 1'b0;
            wait_cnt    <= 8'd0;
            stall_cnt   <= 32'd0;
            flush_cnt   <= 32'd0;
            mem_timeout <= 1'b0;
        end else begin
            state      <= state_next;
            pend_flush <= pend_flush_next;
            if (state != ST_WAIT && state_next == ST_WAIT) begin
                wait_cnt <= 8'd0;
            end else if (state == ST_WAIT && ms) begin
                wait_cnt <= wait_inc;
                if (wait_inc >= TIMEOUT_W)
                    mem_timeout <= 1'b1;
            end
            if (!pc_wen)
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect_acc)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign bus.o_pc_wen       = pc_wen;
    assign bus.o_ifid_wen     = ifid_wen;
    assign bus.o_ifid_bubble  = ifid_bubble;
    assign bus.o_idex_wen     = idex_wen;
    assign bus.o_idex_bubble  = idex_bubble;
    assign bus.o_exmem_wen    = exmem_wen;
    assign bus.o_exmem_bubble = exmem_bubble;
    assign bus.o_memwb_wen    = memwb_wen;
    assign bus.o_memwb_bubble = memwb_bubble;
    assign bus.o_state        = state;
    assign bus.o_stall_cnt    = stall_cnt;
    assign bus.o_flush_cnt    = flush_cnt;
    assign bus.o_mem_timeout  = mem_timeout;

endmodule

// File: tb/tb_ysyx_22050078_pipe_hazard_ctrl.sv
// Scoreboard bench for the hazard controller: each step pushes its expected
// outputs when driven and pops them when the outputs are sampled mid-cycle.
module tb_ysyx_22050078_pipe_hazard_ctrl;

    // {pc, ifid wen/bub, idex wen/bub, exmem wen/bub, memwb wen/bub}
    localparam logic [8:0] C_RST  = 9'b0_00_00_00_00;
    localparam logic [8:0] C_NORM = 9'b1_10_10_10_10;
    localparam logic [8:0] C_MS   = 9'b0_00_00_00_11;
    localparam logic [8:0] C_RED  = 9'b1_11_11_10_10;
    localparam logic [8:0] C_LU   = 9'b0_00_11_10_10;
    localparam logic [8:0] C_LUF  = 9'b0_01_11_10_10;
    localparam logic [8:0] C_NOV  = 9'b0_11_10_10_10;
    localparam logic [8:0] C_FL   = 9'b1_11_10_10_10;

    typedef struct {
        logic       rst;
        logic       red;
        logic       req;
        logic       ack;
        logic       ifv;
        logic       memrd;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       r1en;
        logic [4:0] rs2;
        logic       r2en;
        logic [8:0] ctrl;
        logic [1:0] st;
        logic       tmo;
    } step_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
    logic [75:0] sb[$];

    ysyx_22050078_pipe_hazard_ctrl_if bus ();

    ysyx_22050078_pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(input logic r, input logic red, input logic req,
                                 input logic ack, input logic ifv, input logic memrd,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic r1en, input logic [4:0] rs2,
                                 input logic r2en, input logic [8:0] ctrl,
                                 input logic [1:0] st, input logic tmo);
        step_t s;
        s.rst = r; s.red = red; s.req = req; s.ack = ack; s.ifv = ifv;
        s.memrd = memrd; s.rd = rd; s.rs1 = rs1; s.r1en = r1en;
        s.rs2 = rs2; s.r2en = r2en; s.ctrl = ctrl; s.st = st; s.tmo = tmo;
        return s;
    endfunction

    function automatic step_t idle(input logic [8:0] ctrl, input logic [1:0] st,
                                   input logic tmo);
        return mk(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, ctrl, st, tmo);
    endfunction

    function automatic logic [75:0] observed();
        return {bus.o_pc_wen, bus.o_ifid_wen, bus.o_ifid_bubble,
                bus.o_idex_wen, bus.o_idex_bubble, bus.o_exmem_wen,
                bus.o_exmem_bubble, bus.o_memwb_wen, bus.o_memwb_bubble,
                bus.o_state, bus.o_stall_cnt, bus.o_flush_cnt, bus.o_mem_timeout};
    endfunction

    // Drives one step and records what the outputs must be before the next edge.
    task automatic apply(input step_t s);
        rst               = s.rst;
        bus.i_ex_redirect = s.red;
        bus.i_lsu_req     = s.req;
        bus.i_lsu_ack     = s.ack;
        bus.i_ifu_valid   = s.ifv;
        bus.i_idex_memrd  = s.memrd;
        bus.i_idex_rd     = s.rd;
        bus.i_idu_rs1     = s.rs1;
        bus.i_idu_rs1_ren = s.r1en;
        bus.i_idu_rs2     = s.rs2;
        bus.i_idu_rs2_ren = s.r2en;
        sb.push_back({s.ctrl, s.st, exp_stall, exp_flush, s.tmo});
        if (s.rst) begin
            exp_stall = 32'd0;
            exp_flush = 32'd0;
        end else begin
            if (!s.ctrl[8])
                exp_stall = exp_stall + 32'd1;
            if (s.red && !(s.req && !s.ack))
                exp_flush = exp_flush + 32'd1;
        end
    endtask

    task automatic test_reset();
        step_t s[$];
        logic [75:0] got, e;
        s.push_back(mk(1, 1, 1, 0, 0, 1, 5'd2, 5'd2, 1, 5'd0, 0, C_RST, 2'd0, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("[TB] FAIL reset step %0d: got %h, want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        logic [75:0] got, e;
        s.push_back(mk(0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, C_LU,   2'd0, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1, C_NORM, 2'd0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 5'd7, 5'd1, 1, 5'd7, 1, C_LU,   2'd0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 5'd7, 5'd1, 1, 5'd7, 0, C_NORM, 2'd0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 0, 5'd5, 5'd5, 1, 5'd0, 0, C_NORM, 2'd0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, C_LU,   2'd0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_NOV,  2'd0, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("[TB] FAIL load_use step %0d: got %h, want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        step_t s[$];
        logic [75:0] got, e;
        s.push_back(mk(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RED,  2'd0, 0));
        s.push_back(idle(C_FL, 2'd1, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        s.push_back(mk(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RED,  2'd0, 0));
        s.push_back(mk(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RED,  2'd1, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_NOV,  2'd1, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        s.push_back(mk(0, 1, 0, 0, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0, C_RED,  2'd0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 1, 5'd3, 5'd3, 1, 5'd0, 0, C_LUF,  2'd1, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("[TB] FAIL redirect step %0d: got %h, want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_stall();
        step_t s[$];
        logic [75:0] got, e;
        s.push_back(mk(0, 1, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS,   2'd0, 0));
        s.push_back(mk(0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS,   2'd2, 0));
        s.push_back(mk(0, 0, 1, 0, 1, 1, 5'd4, 5'd4, 1, 5'd0, 0, C_MS,   2'd2, 0));
        s.push_back(mk(0, 0, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_NORM, 2'd2, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        s.push_back(mk(0, 1, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS,   2'd0, 0));
        s.push_back(mk(0, 1, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RED,  2'd2, 0));
        s.push_back(idle(C_FL, 2'd1, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("[TB] FAIL mem_stall step %0d: got %h, want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_wait();
        step_t s[$];
        logic [75:0] got, e;
        s.push_back(mk(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RED,  2'd0, 0));
        s.push_back(mk(0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS,   2'd1, 0));
        s.push_back(mk(0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS,   2'd2, 0));
        s.push_back(mk(0, 0, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_NORM, 2'd2, 0));
        s.push_back(idle(C_FL, 2'd1, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("[TB] FAIL flush_wait step %0d: got %h, want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        step_t s[$];
        logic [75:0] got, e;
        s.push_back(mk(0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS, 2'd0, 0));
        for (int k = 0; k < 4; k++)
            s.push_back(mk(0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS, 2'd2, 0));
        s.push_back(mk(0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS,   2'd2, 1));
        s.push_back(mk(0, 0, 1, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_NORM, 2'd2, 1));
        s.push_back(idle(C_NORM, 2'd0, 1));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("[TB] FAIL timeout step %0d: got %h, want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_wait();
        step_t s[$];
        logic [75:0] got, e;
        s.push_back(mk(0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS,  2'd0, 1));
        s.push_back(mk(0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_MS,  2'd2, 1));
        s.push_back(mk(1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RST, 2'd2, 1));
        s.push_back(idle(C_NORM, 2'd0, 0));
        s.push_back(idle(C_NORM, 2'd0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            got = observed();
            e = sb.pop_front();
            n_vec++;
            if (got !== e) begin
                n_miss++;
                $display("[TB] FAIL reset_in_wait step %0d: got %h, want %h", i, got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        rst               = 1'b1;
        bus.i_ex_redirect = 1'b0;
        bus.i_lsu_req     = 1'b0;
        bus.i_lsu_ack     = 1'b0;
        bus.i_ifu_valid   = 1'b1;
        bus.i_idex_memrd  = 1'b0;
        bus.i_idex_rd     = 5'd0;
        bus.i_idu_rs1     = 5'd0;
        bus.i_idu_rs1_ren = 1'b0;
        bus.i_idu_rs2     = 5'd0;
        bus.i_idu_rs2_ren = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_load_use();
        test_redirect();
        test_mem_stall();
        test_flush_wait();
        test_timeout();
        test_reset_in_wait();

        if (sb.size() != 0) begin
            n_miss++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
